// File: rtl/grf_wb.sv
// Writeback-side general register file: 32 x 32-bit registers with $0 hardwired to zero,
// two combinational read ports with write-through bypass, a latched status-flag register and a commit counter.
module grf_wb #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          flag_we,
   input  logic          zero_in,
   input  logic          carry_in,
   input  logic          negative_in,
   input  logic          overflow_in,
   output logic [3:0]    flags,
   output logic [DW-1:0] wr_count
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [3:0]    flags_q;
   logic [3:0]    flags_d;
   logic [DW-1:0] wr_count_q;
   logic [DW-1:0] wr_count_d;
   logic          commit;

   // A write only commits (and is only counted) when it targets a nonzero register.
   assign commit = we && (wa != '0);

   always_comb begin
      regs_d = regs_q;
      if (commit) begin
         regs_d[wa] = wd;
      end
      regs_d[0]  = '0;
      wr_count_d = wr_count_q + {{(DW-1){1'b0}}, commit};
      flags_d    = flags_q;
      if (flag_we) begin
         flags_d = {zero_in, carry_in, negative_in, overflow_in};
      end
   end

   // Reset wins over any write or flag update presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         flags_q    <= '0;
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         flags_q    <= flags_d;
         wr_count_q <= wr_count_d;
      end
   end

   always_comb begin
      rd1 = regs_q[ra1];
      if (commit && (wa == ra1)) begin
         rd1 = wd;
      end
      if (ra1 == '0) begin
         rd1 = '0;
      end
      rd2 = regs_q[ra2];
      if (commit && (wa == ra2)) begin
         rd2 = wd;
      end
      if (ra2 == '0) begin
         rd2 = '0;
      end
   end

   assign flags    = flags_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_grf_wb.sv
// Self-checking bench for grf_wb: directed scenarios plus randomized traffic against an array-based reference model.
module tb_grf_wb;

   logic        clk;
   logic        reset_n;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] rd1, rd2, wd, wr_count;
   logic        we, flag_we, zero_in, carry_in, negative_in, overflow_in;
   logic [3:0]  flags;

   logic [31:0] m_regs [32];
   logic [31:0] m_count;
   logic [3:0]  m_flags;
   int          checks;
   int          passed;

   grf_wb dut (
      .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we), .wa(wa), .wd(wd), .flag_we(flag_we), .zero_in(zero_in),
      .carry_in(carry_in), .negative_in(negative_in), .overflow_in(overflow_in),
      .flags(flags), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural read as seen by the next instruction: $0 is zero, a pending write is visible.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   task automatic model_edge();
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_count = 32'd0;
         m_flags = 4'd0;
      end else begin
         if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_count = m_count + 32'd1;
         end
         if (flag_we) m_flags = {zero_in, carry_in, negative_in, overflow_in};
      end
   endtask

   // Clock one edge, keep the model in step, and return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we = 0; wa = 0; wd = 0; flag_we = 0;
      zero_in = 0; carry_in = 0; negative_in = 0; overflow_in = 0;
   endtask

   task automatic test_reset();
      reset_n = 0;
      idle_inputs();
      we = 1; wa = 5'd4; wd = $urandom; flag_we = 1; zero_in = 1;
      @(negedge clk);
      tick();
      tick();
      reset_n = 1;
      idle_inputs();
      ra1 = 5'd5; ra2 = 5'd31;
      #1;
      checks++; if (rd1 !== 32'd0) $display("[TB] FAIL reset_rd1 got %h expected %h", rd1, 32'd0); else passed++;
      checks++; if (rd2 !== 32'd0) $display("[TB] FAIL reset_rd2 got %h expected %h", rd2, 32'd0); else passed++;
      checks++; if (flags !== 4'b0000) $display("[TB] FAIL reset_flags got %b expected %b", flags, 4'b0000); else passed++;
      checks++; if (wr_count !== 32'd0) $display("[TB] FAIL reset_count got %h expected %h", wr_count, 32'd0); else passed++;
   endtask

   task automatic test_write_read();
      we = 1; wa = 5'd8; wd = 32'h1234_0000;
      tick();
      we = 0; ra1 = 5'd8;
      #1;
      checks++; if (rd1 !== 32'h1234_0000) $display("[TB] FAIL write_read got %h expected %h", rd1, 32'h1234_0000); else passed++;
      checks++; if (wr_count !== 32'd1) $display("[TB] FAIL write_count got %h expected %h", wr_count, 32'd1); else passed++;
   endtask

   task automatic test_bypass();
      we = 0; ra1 = 5'd9; ra2 = 5'd9;
      #1;
      checks++; if (rd1 !== 32'd0) $display("[TB] FAIL bypass_pre got %h expected %h", rd1, 32'd0); else passed++;
      we = 1; wa = 5'd9; wd = 32'hDEAD_BEEF;
      #1;
      checks++; if (rd1 !== 32'hDEAD_BEEF) $display("[TB] FAIL bypass_rd1 got %h expected %h", rd1, 32'hDEAD_BEEF); else passed++;
      checks++; if (rd2 !== 32'hDEAD_BEEF) $display("[TB] FAIL bypass_rd2 got %h expected %h", rd2, 32'hDEAD_BEEF); else passed++;
      tick();
      we = 0; wd = 32'h0;
      #1;
      checks++; if (rd1 !== 32'hDEAD_BEEF) $display("[TB] FAIL bypass_post_rd1 got %h expected %h", rd1, 32'hDEAD_BEEF); else passed++;
      checks++; if (rd2 !== 32'hDEAD_BEEF) $display("[TB] FAIL bypass_post_rd2 got %h expected %h", rd2, 32'hDEAD_BEEF); else passed++;
      checks++; if (wr_count !== 32'd2) $display("[TB] FAIL bypass_count got %h expected %h", wr_count, 32'd2); else passed++;
   endtask

   task automatic test_zero_reg();
      we = 1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd8;
      #1;
      checks++; if (rd1 !== 32'd0) $display("[TB] FAIL zero_pre got %h expected %h", rd1, 32'd0); else passed++;
      checks++; if (rd2 !== 32'h1234_0000) $display("[TB] FAIL zero_no_alias got %h expected %h", rd2, 32'h1234_0000); else passed++;
      tick();
      we = 0;
      #1;
      checks++; if (rd1 !== 32'd0) $display("[TB] FAIL zero_post got %h expected %h", rd1, 32'd0); else passed++;
      checks++; if (wr_count !== 32'd2) $display("[TB] FAIL zero_count got %h expected %h", wr_count, 32'd2); else passed++;
   endtask

   task automatic test_flags_reset_priority();
      flag_we = 1; zero_in = 1; carry_in = 0; negative_in = 0; overflow_in = 0;
      tick();
      flag_we = 0; zero_in = 0;
      #1;
      checks++; if (flags !== 4'b1000) $display("[TB] FAIL flags_latch got %b expected %b", flags, 4'b1000); else passed++;
      flag_we = 0; carry_in = 1; overflow_in = 1;
      tick();
      checks++; if (flags !== 4'b1000) $display("[TB] FAIL flags_hold got %b expected %b", flags, 4'b1000); else passed++;
      reset_n = 0; we = 1; wa = 5'd3; wd = 32'd7;
      flag_we = 1; zero_in = 1; carry_in = 1; negative_in = 1; overflow_in = 1;
      tick();
      reset_n = 1;
      idle_inputs();
      ra1 = 5'd3; ra2 = 5'd9;
      #1;
      checks++; if (rd1 !== 32'd0) $display("[TB] FAIL rstprio_reg3 got %h expected %h", rd1, 32'd0); else passed++;
      checks++; if (rd2 !== 32'd0) $display("[TB] FAIL rstprio_reg9 got %h expected %h", rd2, 32'd0); else passed++;
      checks++; if (flags !== 4'b0000) $display("[TB] FAIL rstprio_flags got %b expected %b", flags, 4'b0000); else passed++;
      checks++; if (wr_count !== 32'd0) $display("[TB] FAIL rstprio_count got %h expected %h", wr_count, 32'd0); else passed++;
   endtask

   task automatic test_counter_wrap();
      force dut.wr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count_q;
      m_count = 32'hFFFF_FFFF;
      #1;
      checks++; if (wr_count !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_preload got %h expected %h", wr_count, 32'hFFFF_FFFF); else passed++;
      we = 1; wa = 5'd1; wd = $urandom;
      tick();
      we = 0;
      #1;
      checks++; if (wr_count !== 32'd0) $display("[TB] FAIL wrap_count got %h expected %h", wr_count, 32'd0); else passed++;
      checks++; if (wr_count !== m_count) $display("[TB] FAIL wrap_model got %h expected %h", wr_count, m_count); else passed++;
   endtask

   task automatic test_back_to_back();
      ra1 = 5'd12; ra2 = 5'd12;
      for (int i = 0; i < 4; i++) begin
         we = 1; wa = 5'd12; wd = $urandom;
         flag_we = 1; {zero_in, carry_in, negative_in, overflow_in} = 4'($urandom);
         #1;
         checks++; if (rd1 !== wd) $display("[TB] FAIL b2b_bypass got %h expected %h", rd1, wd); else passed++;
         tick();
         checks++; if (flags !== m_flags) $display("[TB] FAIL b2b_flags got %b expected %b", flags, m_flags); else passed++;
      end
      we = 0; flag_we = 0;
      #1;
      checks++; if (rd2 !== m_regs[12]) $display("[TB] FAIL b2b_final got %h expected %h", rd2, m_regs[12]); else passed++;
      checks++; if (wr_count !== m_count) $display("[TB] FAIL b2b_count got %h expected %h", wr_count, m_count); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] e1, e2;
      for (int n = 0; n < 400; n++) begin
         reset_n = ($urandom_range(0, 39) != 0);
         we      = $urandom_range(0, 1);
         wa      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wd      = $urandom;
         ra1     = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
         ra2     = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 3));
         flag_we = $urandom_range(0, 1);
         {zero_in, carry_in, negative_in, overflow_in} = 4'($urandom);
         #1;
         if (reset_n) begin
            e1 = exp_read(ra1);
            e2 = exp_read(ra2);
            checks++; if (rd1 !== e1) $display("[TB] FAIL rand_rd1 ra1=%0d got %h expected %h", ra1, rd1, e1); else passed++;
            checks++; if (rd2 !== e2) $display("[TB] FAIL rand_rd2 ra2=%0d got %h expected %h", ra2, rd2, e2); else passed++;
         end
         tick();
         checks++; if (flags !== m_flags) $display("[TB] FAIL rand_flags got %b expected %b", flags, m_flags); else passed++;
         checks++; if (wr_count !== m_count) $display("[TB] FAIL rand_count got %h expected %h", wr_count, m_count); else passed++;
      end
      reset_n = 1;
      idle_inputs();
   endtask

   initial begin
      checks = 0;
      passed = 0;
      ra1 = 0; ra2 = 0;
      m_count = 0; m_flags = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_flags_reset_priority();
      test_counter_wrap();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
